// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad combination lock.
package lock_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned KEY_W   = 5;
  localparam int unsigned TRIES_W = 3;

  localparam logic [KEY_W-1:0] KEY_ENTER = 5'd16;
  localparam logic [KEY_W-1:0] KEY_CLEAR = 5'd17;

  typedef enum logic [STATE_W-1:0] {
    ST_SET     = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ENTRY   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_LOCKOUT = 3'd4,
    ST_ALARM   = 3'd5
  } lock_state_e;

  // Larger of two tick counts, never below 1, for sizing the shared timer.
  function automatic int unsigned ticks_max(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : m;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Down-counter shared by OPEN and LOCKOUT; done pulses for one cycle
// in the cycle before the count would reach zero.
module lock_timer #(
  parameter int unsigned TW = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          done_o
);

  logic [TW-1:0] count_q, count_d;
  logic          done_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - TW'(1);
    end
  end

  // done_q is high exactly while count_q == 1, so the consumer moves on
  // the edge that completes the requested number of cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= (count_d == TW'(1));
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/combo_lock.sv
// Keypad combination lock: programmable code, retry limit with timed
// lockout, terminal alarm, and timed auto-relock while open.
module combo_lock
  import lock_pkg::*;
#(
  parameter int unsigned CODE_LEN      = 8,
  parameter int unsigned DIGIT_W       = 4,
  parameter int unsigned MAX_TRIES     = 3,
  parameter int unsigned LOCKOUT_TICKS = 500,
  parameter int unsigned OPEN_TICKS    = 1000
) (
  input  logic                               hz100,
  input  logic                               reset,
  input  logic                               key_valid,
  input  logic [KEY_W-1:0]                   key_code,
  output logic [STATE_W-1:0]                 state,
  output logic [CODE_LEN*DIGIT_W-1:0]        code_out,
  output logic [$clog2(CODE_LEN+1)-1:0]      digit_idx,
  output logic [TRIES_W-1:0]                 tries_left,
  output logic                               unlocked,
  output logic                               lockout,
  output logic                               alarm
);

  localparam int unsigned CW        = CODE_LEN * DIGIT_W;
  localparam int unsigned IW        = $clog2(CODE_LEN + 1);
  localparam int unsigned LOCK_LOAD = (LOCKOUT_TICKS < 1) ? 1 : LOCKOUT_TICKS;
  localparam int unsigned OPEN_LOAD = (OPEN_TICKS < 1) ? 1 : OPEN_TICKS;
  localparam int unsigned TW        = $clog2(ticks_max(LOCK_LOAD, OPEN_LOAD) + 1);

  localparam logic [KEY_W-1:0]   DIG_LIM    = KEY_W'(2 ** DIGIT_W);
  localparam logic [TRIES_W-1:0] TRIES_INIT = TRIES_W'(MAX_TRIES);
  localparam logic [IW-1:0]      IDX_FULL   = IW'(CODE_LEN);
  localparam logic [IW-1:0]      IDX_LAST   = IW'(CODE_LEN - 1);

  lock_state_e        state_q, state_d;
  logic [CW-1:0]      code_q, code_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic               mism_q, mism_d;
  logic               unlocked_q, lockout_q, alarm_q;

  logic               tmr_load;
  logic [TW-1:0]      tmr_val;
  logic               tmr_done;

  logic               is_digit, is_enter, is_clear;
  logic [DIGIT_W-1:0] digit;
  logic [DIGIT_W-1:0] exp_digit;
  logic               mism_now;

  // Key decode: digits above the radix and codes 18+ fall through as no-ops.
  assign is_digit = key_valid && (key_code < 5'd16) && (key_code < DIG_LIM);
  assign is_enter = key_valid && (key_code == KEY_ENTER);
  assign is_clear = key_valid && (key_code == KEY_CLEAR);
  assign digit    = key_code[DIGIT_W-1:0];

  // Stored digit that the current ENTRY position is compared against.
  always_comb begin
    int unsigned shamt;
    shamt     = (CODE_LEN - 1 - int'(idx_q)) * DIGIT_W;
    exp_digit = DIGIT_W'(code_q >> shamt);
  end

  assign mism_now = mism_q | (digit != exp_digit);

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    idx_d    = idx_q;
    tries_d  = tries_q;
    mism_d   = mism_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    unique case (state_q)
      ST_SET: begin
        if (is_digit) begin
          code_d = (code_q << DIGIT_W) | CW'(digit);
          if (idx_q != IDX_FULL) begin
            idx_d = idx_q + IW'(1);
          end
        end else if (is_enter && (idx_q == IDX_FULL)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (is_clear) begin
          code_d = '0;
          idx_d  = '0;
          mism_d = 1'b0;
        end
      end

      ST_IDLE: begin
        if (is_enter) begin
          state_d = ST_ENTRY;
          idx_d   = '0;
        end
      end

      ST_ENTRY: begin
        if (is_digit) begin
          if (idx_q == IDX_LAST) begin
            idx_d  = '0;
            mism_d = 1'b0;
            if (!mism_now) begin
              state_d  = ST_OPEN;
              tries_d  = TRIES_INIT;
              tmr_load = 1'b1;
              tmr_val  = TW'(OPEN_LOAD);
            end else begin
              tries_d = tries_q - TRIES_W'(1);
              if (tries_d == '0) begin
                state_d = ST_ALARM;
              end else begin
                state_d  = ST_LOCKOUT;
                tmr_load = 1'b1;
                tmr_val  = TW'(LOCK_LOAD);
              end
            end
          end else begin
            idx_d  = idx_q + IW'(1);
            mism_d = mism_now;
          end
        end else if (is_clear) begin
          idx_d  = '0;
          mism_d = 1'b0;
        end
      end

      // Expiry takes priority so a coincident ENTER still yields one relock.
      ST_OPEN: begin
        if (tmr_done || is_enter) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (is_clear) begin
          state_d = ST_SET;
          code_d  = '0;
          idx_d   = '0;
          mism_d  = 1'b0;
        end
      end

      ST_LOCKOUT: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end

      ST_ALARM: begin
        state_d = ST_ALARM;
      end

      default: begin
        state_d = ST_SET;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      state_q    <= ST_SET;
      code_q     <= '0;
      idx_q      <= '0;
      tries_q    <= TRIES_INIT;
      mism_q     <= 1'b0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      idx_q      <= idx_d;
      tries_q    <= tries_d;
      mism_q     <= mism_d;
      unlocked_q <= (state_d == ST_OPEN);
      lockout_q  <= (state_d == ST_LOCKOUT);
      alarm_q    <= (state_d == ST_ALARM);
    end
  end

  lock_timer #(
    .TW(TW)
  ) u_timer (
    .clk_i      (hz100),
    .rst_i      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  assign state      = state_q;
  assign code_out   = code_q;
  assign digit_idx  = idx_q;
  assign tries_left = tries_q;
  assign unlocked   = unlocked_q;
  assign lockout    = lockout_q;
  assign alarm      = alarm_q;

endmodule

// File: doc/combo_lock.md
COMBO_LOCK -- requirements
Module: combo_lock

Interface
REQ-001 SHALL have parameter CODE_LEN, default 8: digits per code, range 1..8.
REQ-002 SHALL have parameter DIGIT_W, default 4: bits per digit, range 1..4.
REQ-003 SHALL have parameter MAX_TRIES, default 3: wrong codes allowed before ALARM, range 1..7.
REQ-004 SHALL have parameter LOCKOUT_TICKS, default 500: LOCKOUT duration in hz100 cycles.
REQ-005 SHALL have parameter OPEN_TICKS, default 1000: OPEN duration before auto-relock.
REQ-006 SHALL have one clock and a synchronous, active-high reset: hz100 and reset.
REQ-007 SHALL have port hz100  in  1  clock.
REQ-008 SHALL have port reset  in  1  synchronous active-high reset.
REQ-009 SHALL have port key_valid  in  1  single-cycle key strobe.
REQ-010 SHALL have port key_code  in  5  key index: 0-15 digit, 16 ENTER, 17 CLEAR, 18+ ignored.
REQ-011 SHALL have port state  out  3  current state encoding.
REQ-012 SHALL have port code_out  out  CODE_LEN*DIGIT_W  programmed code, first digit in MSB slice.
REQ-013 SHALL have port digit_idx  out  $clog2(CODE_LEN+1)  digits entered in the current SET or ENTRY pass.
REQ-014 SHALL have port tries_left  out  3  remaining attempts.
REQ-015 SHALL have ports unlocked, lockout, alarm  out  1 each  high in OPEN, LOCKOUT and ALARM respectively.

Function
REQ-016 SHALL use states SET=0, IDLE=1, ENTRY=2, OPEN=3, LOCKOUT=4, ALARM=5; all outputs registered, updating on the hz100 edge that samples key_valid.
REQ-017 SHALL treat a digit key as key_code<16 and key_code<2**DIGIT_W; all other codes except 16 and 17 SHALL be ignored.
REQ-018 SET, digit: SHALL shift code_out left by DIGIT_W, insert the digit at the LSBs and increment digit_idx, saturating at CODE_LEN; digits beyond CODE_LEN still shift.
REQ-019 SET, ENTER: SHALL go to IDLE and clear digit_idx when digit_idx==CODE_LEN; otherwise SHALL be ignored.
REQ-020 SET/ENTRY, CLEAR: SHALL zero digit_idx and a mismatch flag; in SET it SHALL also zero code_out.
REQ-021 IDLE, ENTER: SHALL go to ENTRY; all other keys SHALL be ignored.
REQ-022 ENTRY, digit i (0-based): SHALL compare against slice CODE_LEN-1-i of code_out, OR any inequality into the mismatch flag and increment digit_idx; there is no early abort.
REQ-023 ENTRY, CODE_LEN-th digit: if there was no mismatch, SHALL go to OPEN, reload tries_left to MAX_TRIES and start the timer.
REQ-024 On a mismatch, SHALL decrement tries_left; if the result is 0, go to ALARM, else go to LOCKOUT and start the timer.
REQ-025 In ENTRY, ENTER SHALL be ignored.
REQ-026 OPEN SHALL go to IDLE on ENTER or timer expiry (OPEN_TICKS cycles after entry); when both occur in the same cycle, it SHALL go to IDLE once.
REQ-027 In OPEN, a key of 17 (CLEAR) SHALL go to SET with code_out and digit_idx zeroed, for reprogramming.
REQ-028 LOCKOUT SHALL ignore all keys and go to IDLE exactly LOCKOUT_TICKS cycles after entry.
REQ-029 ALARM SHALL be terminal until reset; keys ignored.
REQ-030 digit_idx SHALL be cleared on every entry to IDLE, ENTRY, OPEN, LOCKOUT and ALARM.

Reset
REQ-031 reset SHALL win over all other inputs in the same cycle.
REQ-032 On reset: state=SET, code_out=0, digit_idx=0, tries_left=MAX_TRIES, mismatch flag=0, timer=0, unlocked=lockout=alarm=0.
REQ-033 Reset mid-ENTRY, mid-OPEN or mid-LOCKOUT SHALL abandon progress with no residual timer count.

Structure
REQ-034 Package lock_pkg SHALL hold the state enum and constants KEY_ENTER=16 and KEY_CLEAR=17.
REQ-035 The down-counter SHALL be sub-module lock_timer, with load, a load value, and a done pulse; it is shared by OPEN and LOCKOUT.

Verification
REQ-036 Default params: reset; keys 1,2,3,4,5,6,7,8, ENTER -> IDLE, code_out=32'h12345678; then ENTER, 1..8 -> OPEN, unlocked=1, tries_left=3.
REQ-037 Code 12345678, ENTRY with 1,2,3,4,5,6,7,9 -> LOCKOUT, tries_left=2; with LOCKOUT_TICKS=5, IDLE exactly 5 cycles later; keys pressed during LOCKOUT have no effect.
REQ-038 Three consecutive wrong codes -> ALARM, alarm=1, tries_left=0; ENTER and digits ignored; reset -> SET.
REQ-039 SET: ENTER after 3 digits ignored (stays SET); CLEAR -> code_out=0, digit_idx=0; key_code=20 ignored.
REQ-040 OPEN with OPEN_TICKS=10 and no key -> IDLE after 10 cycles; ENTER on the expiry cycle -> single transition to IDLE.
REQ-041 CODE_LEN=4, DIGIT_W=3: digit key 9 ignored; code 7,0,5,1 -> code_out=12'o7051; unlock succeeds.
